// File: rtl/sevenseg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment driver.
// Segment patterns are logical (1 = lit), bit 6 = a ... bit 0 = g.
package sevenseg_pkg;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    localparam logic [6:0] SEG_UNLIT = 7'h00;

    function automatic logic [6:0] hex2seg(input logic [3:0] hex);
        return SEG_TABLE[hex];
    endfunction

    // Counter width helper: never narrower than one bit.
    function automatic int unsigned min1_clog2(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sevenseg_hex_decode.sv
// Combinational hex nibble to logical seven-segment pattern.
module sevenseg_hex_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex2seg(hex_i);

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with double-buffered value,
// leading-zero blanking, per-digit decimal points and an inter-digit gap.
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lzb_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done,
    output logic                    pending
);

    localparam int DW    = min1_clog2(CLK_DIV);
    localparam int IW    = min1_clog2(NUM_DIGITS);
    localparam int SLOTS = 1 << IW;

    localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? ~SEG_UNLIT : SEG_UNLIT;
    localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};

    logic [DW-1:0]           div_cnt_q;
    logic [IW-1:0]           idx_q;
    logic [4*NUM_DIGITS-1:0] shadow_val_q, disp_val_q;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, disp_dp_q;
    logic                    shadow_lzb_q, disp_lzb_q;
    logic                    pending_q;
    logic [6:0]              seg_q;
    logic                    dp_q;
    logic [NUM_DIGITS-1:0]   an_q;
    logic                    frame_done_q;

    logic tick, last_idx, boundary;

    assign tick     = (div_cnt_q == DW'(CLK_DIV - 1));
    assign last_idx = (idx_q == IW'(NUM_DIGITS - 1));
    assign boundary = tick && last_idx;

    // upper_zero[i]: display nibbles NUM_DIGITS-1 down to i are all zero.
    logic [NUM_DIGITS:0]   upper_zero;
    logic [3:0]            nib_arr [SLOTS];
    logic [SLOTS-1:0]      blank_vec;
    logic [SLOTS-1:0]      dp_vec;
    logic [NUM_DIGITS-1:0] an_onehot;

    assign upper_zero[NUM_DIGITS] = 1'b1;

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            if (gi < NUM_DIGITS) begin : g_digit
                assign nib_arr[gi]    = disp_val_q[4*gi +: 4];
                assign upper_zero[gi] = (disp_val_q[4*gi +: 4] == 4'h0) && upper_zero[gi+1];
                assign blank_vec[gi]  = disp_lzb_q && upper_zero[gi] && (gi != 0);
                assign dp_vec[gi]     = disp_dp_q[gi];
                assign an_onehot[gi]  = (idx_q == IW'(gi));
            end else begin : g_pad
                assign nib_arr[gi]   = 4'h0;
                assign blank_vec[gi] = 1'b0;
                assign dp_vec[gi]    = 1'b0;
            end
        end
    endgenerate

    logic [6:0] dec_seg;

    sevenseg_hex_decode u_decode (
        .hex_i (nib_arr[idx_q]),
        .seg_o (dec_seg)
    );

    logic [6:0]            seg_d;
    logic                  dp_d;
    logic [NUM_DIGITS-1:0] an_d;
    logic [NUM_DIGITS-1:0] an_logical;

    always_comb begin
        seg_d      = blank_vec[idx_q] ? SEG_UNLIT : dec_seg;
        dp_d       = dp_vec[idx_q];
        an_logical = (div_cnt_q >= DW'(BLANK_CYCLES)) ? an_onehot : '0;
        if (SEG_ACTIVE_LOW) begin
            seg_d = ~seg_d;
            dp_d  = ~dp_d;
        end
        an_d = AN_ACTIVE_LOW ? ~an_logical : an_logical;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q    <= '0;
            idx_q        <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            shadow_lzb_q <= 1'b0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            disp_lzb_q   <= 1'b0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            an_q         <= AN_OFF;
        end else begin
            div_cnt_q    <= tick ? '0 : div_cnt_q + 1'b1;
            if (tick) begin
                idx_q <= last_idx ? '0 : idx_q + 1'b1;
            end
            frame_done_q <= boundary;

            if (load) begin
                shadow_val_q <= value;
                shadow_dp_q  <= dp_in;
                shadow_lzb_q <= lzb_en;
            end

            // A load coinciding with the frame boundary bypasses the shadow.
            if (load && boundary) begin
                disp_val_q <= value;
                disp_dp_q  <= dp_in;
                disp_lzb_q <= lzb_en;
                pending_q  <= 1'b0;
            end else if (load) begin
                pending_q  <= 1'b1;
            end else if (boundary && pending_q) begin
                disp_val_q <= shadow_val_q;
                disp_dp_q  <= shadow_dp_q;
                disp_lzb_q <= shadow_lzb_q;
                pending_q  <= 1'b0;
            end

            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Scoreboard bench: stimulus queues expected per-digit presentations, a
// monitor pops one whenever a new digit enable appears on the pins.
module tb_sevenseg_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        lzb_en = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;
    logic        pending;

    sevenseg_scan_driver #(
        .NUM_DIGITS     (4),
        .CLK_DIV        (4),
        .BLANK_CYCLES   (1),
        .AN_ACTIVE_LOW  (1'b1),
        .SEG_ACTIVE_LOW (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .lzb_en     (lzb_en),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       pend;
        int         tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic l);
        value  = v;
        dp_in  = d;
        lzb_en = l;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    // segs = {digit3, digit2, digit1, digit0}; dps/pends indexed by digit.
    task automatic push_frame(input int tag, input logic [27:0] segs,
                              input logic [3:0] dps, input logic [3:0] pends);
        exp_t rec;
        for (int d = 0; d < 4; d++) begin
            rec.an   = ~(4'b0001 << d);
            rec.seg  = segs[d*7 +: 7];
            rec.dp   = dps[d];
            rec.pend = pends[d];
            rec.tag  = tag * 10 + d;
            sb_q.push_back(rec);
        end
    endtask

    task automatic wait_frame();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!frame_done && k < 40);
        check("frame_done_seen", frame_done, 1'b1);
    endtask

    task automatic drain();
        int k = 0;
        while (sb_q.size() > 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("scoreboard_drain", sb_q.size(), 0);
        sb_q.delete();
    endtask

    // Monitor: a digit presentation is the first sample of a new active enable.
    initial begin : monitor
        logic [3:0] prev_an;
        exp_t       rec;
        prev_an = 4'hF;
        forever begin
            @(negedge clk);
            if (an != 4'hF && an !== prev_an && sb_q.size() > 0) begin
                rec = sb_q.pop_front();
                $display("[TB] slot %0d: an=%b seg=%h dp=%b pending=%b", rec.tag, an, seg, dp, pending);
                check($sformatf("slot%0d_an", rec.tag), an, rec.an);
                check($sformatf("slot%0d_seg", rec.tag), seg, rec.seg);
                check($sformatf("slot%0d_dp", rec.tag), dp, rec.dp);
                check($sformatf("slot%0d_pending", rec.tag), pending, rec.pend);
                check($sformatf("slot%0d_gap", rec.tag), prev_an, 4'hF);
            end
            prev_an = an;
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h00);
        check("rst_dp", dp, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_pending", pending, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("first_cycle_an", an, 4'hF);

        // Scan 12AF with dp on digit 2, two frames
        do_load(16'h12AF, 4'b0100, 1'b0);
        check("scan_pending", pending, 1'b1);
        wait_frame();
        push_frame(1, {7'h30, 7'h6D, 7'h77, 7'h47}, 4'b0100, 4'b0000);
        drain();
        wait_frame();
        push_frame(2, {7'h30, 7'h6D, 7'h77, 7'h47}, 4'b0100, 4'b0000);
        drain();

        // Leading-zero blanking on and off
        do_load(16'h0050, 4'b0000, 1'b1);
        wait_frame();
        push_frame(3, {7'h00, 7'h00, 7'h5B, 7'h7E}, 4'b0000, 4'b0000);
        drain();
        do_load(16'h0050, 4'b0000, 1'b0);
        wait_frame();
        push_frame(4, {7'h7E, 7'h7E, 7'h5B, 7'h7E}, 4'b0000, 4'b0000);
        drain();

        // Mid-frame load during digit 1: old value stays, pending raised
        wait_frame();
        push_frame(5, {7'h7E, 7'h7E, 7'h5B, 7'h7E}, 4'b0000, 4'b1110);
        @(negedge clk);
        check("frame_done_pulse_width", frame_done, 1'b0);
        repeat (3) @(negedge clk);
        do_load(16'h8888, 4'b0000, 1'b0);
        drain();
        check("mid_pending_before_boundary", pending, 1'b1);
        wait_frame();
        push_frame(6, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b0000, 4'b0000);
        drain();

        // Two loads in one frame: last write wins
        wait_frame();
        repeat (2) @(negedge clk);
        do_load(16'h1111, 4'b0000, 1'b0);
        repeat (2) @(negedge clk);
        do_load(16'h2222, 4'b0000, 1'b0);
        check("overwrite_pending", pending, 1'b1);
        wait_frame();
        push_frame(7, {7'h6D, 7'h6D, 7'h6D, 7'h6D}, 4'b0000, 4'b0000);
        drain();

        // Load exactly on the boundary cycle goes straight to display
        wait_frame();
        repeat (15) @(negedge clk);
        do_load(16'h3333, 4'b1001, 1'b0);
        check("boundary_frame_done", frame_done, 1'b1);
        check("boundary_pending", pending, 1'b0);
        push_frame(8, {7'h79, 7'h79, 7'h79, 7'h79}, 4'b1001, 4'b0000);
        drain();

        // Reset during digit 2: outputs drop, display clears, scan restarts
        wait_frame();
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_an", an, 4'hF);
        check("midrst_seg", seg, 7'h00);
        check("midrst_dp", dp, 1'b0);
        check("midrst_frame_done", frame_done, 1'b0);
        check("midrst_pending", pending, 1'b0);
        rst = 1'b0;
        push_frame(9, {7'h7E, 7'h7E, 7'h7E, 7'h7E}, 4'b0000, 4'b0000);
        drain();
        wait_frame();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
